connector_top_part1: RTL and testbench
======================================

// Module: connector_top_part1
// PURPOSE
//  Read side of the connector: absorbs the per-channel write strobes (wen/data) fed by the
//  connector front-end, buffers each channel in a small FIFO and drains them through a
//  round-robin arbiter onto a single valid/ready read stream tagged with the channel id.
//  It sits between the connector write ports and the downstream consumer, in one clock domain.
// PARAMETERS
//  NUM_CH   3   number of write channels (1..8)
//  DW       8   data width per channel
//  DEPTH    4   entries per channel FIFO (power of 2, >=2)
// PORTS
//  clk0       in   1          single clock, rising edge
//  resetn     in   1          asynchronous active-low reset
//  wen        in   NUM_CH     per-channel write strobe, one beat per cycle while high
//  wdata      in   NUM_CH*DW  channel i data at [i*DW +: DW]
//  rd_valid   out  1          read beat available
//  rd_ready   in   1          consumer accepts beat when rd_valid & rd_ready
//  rd_data    out  DW         read data
//  rd_ch      out  $clog2(NUM_CH) (min 1)  source channel of rd_data
//  ovf        out  NUM_CH     sticky per-channel overflow flag
//  ovf_clr    in   NUM_CH     per-channel overflow clear
//  freeze     in   1          present only with CONNECTOR_FREEZE_EN
// BEHAVIOUR
//  Reset (async assert, sync release): rd_valid=0, rd_data=0, rd_ch=0, ovf=0, FIFOs empty,
//   RR pointer = channel 0 has top priority. Reset mid-transfer discards all buffered beats.
//  Write: wen[i] pushes wdata[i] when FIFO i not full, or full and popped the same cycle
//   (push accepted). Otherwise the beat is dropped and ovf[i] sets on the next edge.
//  ovf[i]: set has priority over ovf_clr[i] in the same cycle.
//  Output register: loads when empty (!rd_valid) or draining (rd_valid & rd_ready).
//   rd_data/rd_ch held stable while rd_valid & !rd_ready. No combinational ready->valid path.
//  Arbiter: on load, grant first non-empty FIFO at or after pointer (wrapping NUM_CH-1 -> 0);
//   pointer then moves to granted+1 mod NUM_CH. No non-empty FIFO -> rd_valid drops on drain.
//  Latency: beat written at edge N into empty FIFO, output idle -> rd_valid high after edge N+1.
//  Throughput: one beat per cycle sustained while rd_ready=1 and any FIFO non-empty.
//  FIFO pointers are log2(DEPTH)+1 bits; full = MSB differs, low bits equal; wrap is natural.
// CONFIGURATION
//  CONNECTOR_FREEZE_EN defined: freeze port exists; while freeze=1 no new grants, the
//   output register holds (an accepted beat drains and rd_valid falls), writes and
//   overflow still operate; RR pointer frozen. Freeze has no effect on reset behaviour.
//  Not defined: no freeze port; arbitration never stalls except on empty/backpressure.
// STRUCTURE
//  connector_pkg: CONN_NUM_CH, CONN_DW constants; typedef conn_data_t (logic [DW-1:0]),
//   conn_ch_t (channel id); function rr_next() for pointer wrap.
//  Sub-module connector_chan_fifo (DW, DEPTH): push/pop/full/empty/rdata, instantiated
//   NUM_CH times via generate; arbiter + output register live in the top.
// TESTING
//  1 single write wen=001 wdata[0]=8'hA5, rd_ready=1 -> rd_valid 2 edges later, rd_data=A5, rd_ch=0.
//  2 wen=111 one cycle with data 11/22/33, rd_ready=1 -> three beats ch0,1,2 in order, back-to-back.
//  3 rd_ready=0, 5 writes to ch1 (DEPTH=4) -> ch1 holds 1 in output + 4 in FIFO, ovf[1]=0;
//    6th write dropped, ovf[1]=1 next edge; ovf_clr[1] -> 0.
//  4 continuous wen=101, rd_ready=1 -> alternating rd_ch 0,2,0,2; ch1 never starved when enabled.
//  5 resetn pulsed low with beats buffered -> rd_valid=0 immediately, ovf=0, next beat from ch0.
//  6 (CONNECTOR_FREEZE_EN) freeze=1 with data queued -> no new rd_valid; release -> resumes at pointer.

Source files
------------

// File: rtl/connector_pkg.sv
// rtl/connector_pkg.sv - shared constants, types and round-robin helper for the connector read side
package connector_pkg;

    localparam int CONN_NUM_CH = 3;
    localparam int CONN_DW     = 8;
    localparam int CONN_DEPTH  = 4;
    localparam int CONN_CW     = (CONN_NUM_CH > 1) ? $clog2(CONN_NUM_CH) : 1;

    typedef logic [CONN_DW-1:0] conn_data_t;
    typedef logic [CONN_CW-1:0] conn_ch_t;

    // Next round-robin pointer: one past the granted channel, wrapping to 0.
    function automatic int rr_next(input int cur, input int num_ch);
        return (cur + 1 >= num_ch) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/connector_chan_fifo.sv
// rtl/connector_chan_fifo.sv - per-channel synchronous FIFO with push-through-when-full
//
// Ports:
//   clk0, resetn        clock, asynchronous active-low reset
//   push, pdata         write strobe and data; accepted when not full, or full and popped this cycle
//   pop                 read strobe; the caller only pops when not empty
//   full, empty         status from registered pointers
//   rdata               head entry, valid while !empty
module connector_chan_fifo
    import connector_pkg::*;
#(
    parameter int DW    = CONN_DW,
    parameter int DEPTH = CONN_DEPTH
) (
    input  logic          clk0,
    input  logic          resetn,
    input  logic          push,
    input  logic [DW-1:0] pdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a beat when its head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk0 or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk0) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= pdata;
    end

endmodule

// File: rtl/connector_top_part1.sv
// rtl/connector_top_part1.sv - per-channel FIFOs drained by a round-robin arbiter onto one read stream
//
// Ports:
//   clk0, resetn        clock, asynchronous active-low reset
//   freeze              stall new grants (only with CONNECTOR_FREEZE_EN defined)
//   wen, wdata          per-channel write strobes, channel i data at [i*DW +: DW]
//   rd_valid, rd_ready  registered read handshake
//   rd_data, rd_ch      read beat and its source channel
//   ovf, ovf_clr        sticky per-channel drop flags and their clears
// Optional feature macro: CONNECTOR_FREEZE_EN
module connector_top_part1
    import connector_pkg::*;
#(
    parameter int NUM_CH = CONN_NUM_CH,
    parameter int DW     = CONN_DW,
    parameter int DEPTH  = CONN_DEPTH,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk0,
    input  logic              resetn,
`ifdef CONNECTOR_FREEZE_EN
    input  logic              freeze,
`endif
    input  logic [NUM_CH-1:0]    wen,
    input  logic [NUM_CH*DW-1:0] wdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DW-1:0]     rd_data,
    output logic [CW-1:0]     rd_ch,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
);

    logic              frz;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [DW-1:0]     fifo_rdata [NUM_CH];
    logic [NUM_CH-1:0] pop_vec;

    logic              rd_valid_q, rd_valid_d;
    logic [DW-1:0]     rd_data_q,  rd_data_d;
    logic [CW-1:0]     rd_ch_q,    rd_ch_d;
    logic [CW-1:0]     ptr_q,      ptr_d;
    logic [NUM_CH-1:0] ovf_q,      ovf_d;

    logic              load;
    logic              found;
    logic [CW-1:0]     grant;

`ifdef CONNECTOR_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        connector_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk0  (clk0),
            .resetn(resetn),
            .push  (wen[g]),
            .pdata (wdata[g*DW +: DW]),
            .pop   (pop_vec[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .rdata (fifo_rdata[g])
        );
    end

    always_comb begin
        found      = 1'b0;
        grant      = '0;
        pop_vec    = '0;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
        ptr_d      = ptr_q;
        load       = (~rd_valid_q | rd_ready) & ~frz;

        // First non-empty channel scanning upward from the pointer, wrapping.
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end

        if (frz) begin
            // Output register holds; an accepted beat still leaves.
            if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
        end else if (load) begin
            rd_valid_d = found;
            if (found) begin
                rd_data_d      = fifo_rdata[grant];
                rd_ch_d        = grant;
                ptr_d          = CW'(rr_next(int'(grant), NUM_CH));
                pop_vec[grant] = 1'b1;
            end
        end

        // Set wins over clear; a beat is dropped only if full and not popped.
        ovf_d = (ovf_q & ~ovf_clr) | (wen & fifo_full & ~pop_vec);
    end

    always_ff @(posedge clk0 or negedge resetn) begin
        if (!resetn) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            ptr_q      <= '0;
            ovf_q      <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_connector_top_part1.sv
// tb/tb_connector_top_part1.sv - directed self-checking bench for connector_top_part1
module tb_connector_top_part1;

    logic        clk0 = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  wen = '0;
    logic [23:0] wdata = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic [1:0]  rd_ch;
    logic [2:0]  ovf;
    logic [2:0]  ovf_clr = '0;
`ifdef CONNECTOR_FREEZE_EN
    logic        freeze = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk0 = ~clk0;

    connector_top_part1 dut (
        .clk0    (clk0),
        .resetn  (resetn),
`ifdef CONNECTOR_FREEZE_EN
        .freeze  (freeze),
`endif
        .wen     (wen),
        .wdata   (wdata),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data (rd_data),
        .rd_ch   (rd_ch),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic do_reset();
        wen = '0; ovf_clr = '0; rd_ready = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%0h exp=0", rd_data); end
        checks++; if (rd_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0h exp=0", rd_ch); end
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL reset_ovf got=%0h exp=0", ovf); end
        resetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rd_ready = 1'b1;
        wen = 3'b001; wdata = 24'h0000A5;
        step();
        wen = '0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0h exp=0", rd_valid); end
        step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0h exp=1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%0h exp=a5", rd_data); end
        checks++; if (rd_ch !== 2'd0) begin errors++; $display("FAIL single_ch got=%0h exp=0", rd_ch); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0h exp=0", rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        do_reset();
        rd_ready = 1'b1;
        wen = 3'b111; wdata = 24'h332211;
        step();
        wen = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rd_valid !== 1'b1 || rd_ch !== 2'(i) || rd_data !== exp_d[i]) begin
                errors++; $display("FAIL b2b_beat%0d got=v%0h ch%0h d%0h exp=v1 ch%0h d%0h", i, rd_valid, rd_ch, rd_data, i, exp_d[i]);
            end
        end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%0h exp=0", rd_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wen = 3'b010; wdata = {8'h00, 8'(8'h40 + k), 8'h00};
            step();
            checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL ovf_fill%0d got=%0h exp=0", k, ovf); end
        end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h40 || rd_ch !== 2'd1) begin
            errors++; $display("FAIL ovf_hold got=v%0h d%0h ch%0h exp=v1 d40 ch1", rd_valid, rd_data, rd_ch);
        end
        wdata = {8'h00, 8'h45, 8'h00};
        step();
        checks++; if (ovf !== 3'b010) begin errors++; $display("FAIL ovf_set got=%0h exp=2", ovf); end
        wdata = {8'h00, 8'h46, 8'h00}; ovf_clr = 3'b010;
        step();
        checks++; if (ovf !== 3'b010) begin errors++; $display("FAIL ovf_set_prio got=%0h exp=2", ovf); end
        wen = '0;
        step();
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL ovf_clr got=%0h exp=0", ovf); end
        ovf_clr = '0;
        rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(8'h40 + k)) begin
                errors++; $display("FAIL ovf_drain%0d got=v%0h d%0h exp=v1 d%0h", k, rd_valid, rd_data, 8'(8'h40 + k));
            end
            step();
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_end got=%0h exp=0", rd_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] ech;
        logic [7:0] ed;
        do_reset();
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wen = 3'b101; wdata = {8'(8'h20 + k), 8'h00, 8'(k)};
            step();
            if (k >= 1) begin
                ech = ((k - 1) % 2 == 0) ? 2'd0 : 2'd2;
                ed  = ((k - 1) % 2 == 0) ? 8'((k - 1) / 2) : 8'(8'h20 + (k - 1) / 2);
                checks++; if (rd_valid !== 1'b1 || rd_ch !== ech || rd_data !== ed) begin
                    errors++; $display("FAIL rr_beat%0d got=v%0h ch%0h d%0h exp=v1 ch%0h d%0h", k - 1, rd_valid, rd_ch, rd_data, ech, ed);
                end
            end
        end
        wen = 3'b111; wdata = {8'h27, 8'h99, 8'h07};
        step();
        checks++; if (rd_ch !== 2'd0 || rd_data !== 8'h03) begin errors++; $display("FAIL rr_pre_ch1 got=ch%0h d%0h exp=ch0 d3", rd_ch, rd_data); end
        wen = 3'b101; wdata = {8'h28, 8'h00, 8'h08};
        step();
        checks++; if (rd_valid !== 1'b1 || rd_ch !== 2'd1 || rd_data !== 8'h99) begin
            errors++; $display("FAIL rr_ch1 got=v%0h ch%0h d%0h exp=v1 ch1 d99", rd_valid, rd_ch, rd_data);
        end
        wen = '0;
        step();
        checks++; if (rd_ch !== 2'd2 || rd_data !== 8'h23) begin errors++; $display("FAIL rr_post_ch1 got=ch%0h d%0h exp=ch2 d23", rd_ch, rd_data); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rd_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wen = (k == 0) ? 3'b110 : 3'b100; wdata = {8'(8'h50 + k), 8'h61, 8'h00};
            step();
        end
        wen = '0;
        checks++; if (ovf !== 3'b100 || rd_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got=ovf%0h v%0h exp=ovf4 v1", ovf, rd_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%0h exp=0", rd_valid); end
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL rst_async_ovf got=%0h exp=0", ovf); end
        step();
        resetn = 1'b1;
        rd_ready = 1'b1;
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_discard got=%0h exp=0", rd_valid); end
        wen = 3'b101; wdata = {8'h78, 8'h00, 8'h77};
        step();
        wen = '0;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_ch !== 2'd0 || rd_data !== 8'h77) begin
            errors++; $display("FAIL rst_first got=v%0h ch%0h d%0h exp=v1 ch0 d77", rd_valid, rd_ch, rd_data);
        end
        step();
        checks++; if (rd_ch !== 2'd2 || rd_data !== 8'h78) begin errors++; $display("FAIL rst_second got=ch%0h d%0h exp=ch2 d78", rd_ch, rd_data); end
    endtask

`ifdef CONNECTOR_FREEZE_EN
    task automatic test_freeze();
        do_reset();
        rd_ready = 1'b1;
        freeze = 1'b1;
        wen = 3'b011; wdata = {8'h00, 8'hB2, 8'hB1};
        step();
        wen = '0;
        step();
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL frz_hold got=%0h exp=0", rd_valid); end
        freeze = 1'b0;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_ch !== 2'd0 || rd_data !== 8'hB1) begin
            errors++; $display("FAIL frz_resume got=v%0h ch%0h d%0h exp=v1 ch0 db1", rd_valid, rd_ch, rd_data);
        end
        freeze = 1'b1;
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL frz_drain got=%0h exp=0", rd_valid); end
        freeze = 1'b0;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_ch !== 2'd1 || rd_data !== 8'hB2) begin
            errors++; $display("FAIL frz_next got=v%0h ch%0h d%0h exp=v1 ch1 db2", rd_valid, rd_ch, rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_round_robin();
        test_reset_midflight();
`ifdef CONNECTOR_FREEZE_EN
        test_freeze();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
